// File: rtl/trace_scheduler_if.sv
// Tracer request/response and pixel-RAM write bundle for trace_scheduler.
// master: the scheduler. slave: the tracer/RAM side.
interface trace_scheduler_if #(
  parameter int CW    = 7,
  parameter int RW    = 6,
  parameter int PIX_W = 12
);
  logic                 trace_req;
  logic [CW-1:0]        col_addr;
  logic [RW-1:0]        row_addr;
  logic                 px_valid;
  logic [PIX_W-1:0]     px_data;
  logic                 ram_we;
  logic [CW+RW-1:0]     ram_waddr;
  logic [PIX_W-1:0]     ram_din;

  modport master (
    output trace_req, col_addr, row_addr, ram_we, ram_waddr, ram_din,
    input  px_valid, px_data
  );

  modport slave (
    input  trace_req, col_addr, row_addr, ram_we, ram_waddr, ram_din,
    output px_valid, px_data
  );
endinterface

// File: rtl/trace_scheduler.sv
// trace_scheduler: walks the (col,row) block grid, issues one trace request
// at a time, writes each returned colour to the pixel RAM at {col,row}.
// Optional feature macro: TRACE_DOUBLE_BUFFER_EN -- when defined, the end of
// each frame waits for a VGA vsync falling edge and swaps the write/read banks.
// Without it, banks are fixed at 0 and frames run back to back.
module trace_scheduler #(
  parameter int COLS  = 128,
  parameter int ROWS  = 64,
  parameter int CW    = 7,
  parameter int RW    = 6,
  parameter int PIX_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               vs,
  trace_scheduler_if.master  bus,
  output logic               wr_bank,
  output logic               rd_bank,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, HOLD} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [PIX_W-1:0]   ram_din_q, ram_din_d;
  logic [CW+RW-1:0]   ram_waddr_q, ram_waddr_d;
  logic               trace_req_q, trace_req_d;
  logic               ram_we_q, ram_we_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic               frame_go;  // HOLD may leave this cycle
  logic               bank_swap;

`ifdef TRACE_DOUBLE_BUFFER_EN
  logic vs_s1_q, vs_s2_q, vs_s3_q;
  logic wr_bank_q, rd_bank_q;
  logic vs_fall;

  // vsync resync (2 flops) plus one more for falling-edge detect; idle high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_s3_q <= 1'b1;
    end else begin
      vs_s1_q <= vs;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
    end
  end

  assign vs_fall   = vs_s3_q & ~vs_s2_q;
  assign frame_go  = vs_fall;

  // banks swap together on the HOLD exit, so they stay complementary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
    end else if (bank_swap) begin
      wr_bank_q <= ~wr_bank_q;
      rd_bank_q <= ~rd_bank_q;
    end
  end

  assign wr_bank = wr_bank_q;
  assign rd_bank = rd_bank_q;
`else
  logic vs_unused;
  assign vs_unused = vs;
  assign frame_go  = 1'b1;
  assign wr_bank   = 1'b0;
  assign rd_bank   = 1'b0;
`endif

  // next-state and next-output logic; outputs are registered from the next state
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    ram_din_d = ram_din_q;
    bank_swap = 1'b0;
    case (state_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        if (run) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.px_valid) begin
          ram_din_d = bus.px_data;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (col_q == COL_LAST && row_q == ROW_LAST) begin
          col_d   = '0;
          row_d   = '0;
          state_d = HOLD;
        end else if (col_q == COL_LAST) begin
          col_d   = '0;
          row_d   = row_q + RW'(1);
          state_d = ISSUE;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = ISSUE;
        end
      end
      HOLD: begin
        if (frame_go) begin
          bank_swap = 1'b1;
          state_d   = run ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    trace_req_d  = (state_d == ISSUE);
    ram_we_d     = (state_d == WRITE);
    ram_waddr_d  = ram_we_d ? {col_d, row_d} : '0;
    // pulse alongside the write strobe of the final block
    frame_done_d = ram_we_d && (col_d == COL_LAST) && (row_d == ROW_LAST);
    busy_d       = (state_d != IDLE);
  end

  // state and registered outputs; reset discards any in-flight block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      ram_din_q    <= '0;
      ram_waddr_q  <= '0;
      trace_req_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ram_din_q    <= ram_din_d;
      ram_waddr_q  <= ram_waddr_d;
      trace_req_q  <= trace_req_d;
      ram_we_q     <= ram_we_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.trace_req = trace_req_q;
  assign bus.col_addr  = col_q;
  assign bus.row_addr  = row_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_din   = ram_din_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// Bench for trace_scheduler on a 4x2 block grid. A tracer model answers each
// request; expected RAM writes go into a queue and are popped on ram_we.
module tb_trace_scheduler;
  localparam int COLS = 4, ROWS = 2, CW = 2, RW = 1, PIX_W = 12;
`ifdef TRACE_DOUBLE_BUFFER_EN
  localparam logic RD_RST = 1'b1;
`else
  localparam logic RD_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic vs  = 1'b1;
  logic wr_bank, rd_bank, frame_done, busy;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int fd_cnt = 0;
  logic [CW+RW+PIX_W-1:0] exp_q[$];

  trace_scheduler_if #(.CW(CW), .RW(RW), .PIX_W(PIX_W)) bus();

  trace_scheduler #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .run(run), .vs(vs), .bus(bus),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_we === 1'b1) begin
        logic [CW+RW+PIX_W-1:0] e;
        we_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%b din=%h, required no write", bus.ram_waddr, bus.ram_din);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ram_waddr, bus.ram_din} !== e) begin
            errors++;
            $display("FAIL ram_write: got addr=%b din=%h, required addr=%b din=%h",
                     bus.ram_waddr, bus.ram_din, e[PIX_W+:CW+RW], e[PIX_W-1:0]);
          end
        end
      end else begin
        checks++;
        if (bus.ram_waddr !== '0) begin
          errors++;
          $display("FAIL idle_waddr: got %b, required 000", bus.ram_waddr);
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (bus.trace_req !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // answer one block; optional stray px_valid while still in ISSUE
  task automatic answer_block(input logic [CW-1:0] c, input logic [RW-1:0] r,
                              input logic [PIX_W-1:0] d, input bit stray);
    int n;
    wait_req(20, n);
    checks++;
    if (bus.trace_req !== 1'b1 || bus.col_addr !== c || bus.row_addr !== r) begin
      errors++;
      $display("FAIL trace_req: got req=%b col=%0d row=%0d, required req=1 col=%0d row=%0d",
               bus.trace_req, bus.col_addr, bus.row_addr, c, r);
      return;
    end
    exp_q.push_back({c, r, d});
    if (stray) begin
      bus.px_valid = 1'b1;
      bus.px_data  = ~d;
    end
    @(negedge clk);
    bus.px_valid = 1'b1;
    bus.px_data  = d;
    @(negedge clk);
    bus.px_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.px_valid = 1'b0;
    bus.px_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (bus.trace_req !== 1'b0) begin errors++; $display("FAIL rst_trace_req: got %b, required 0", bus.trace_req); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b, required 0", bus.ram_we); end
    checks++; if (bus.ram_din !== '0) begin errors++; $display("FAIL rst_ram_din: got %h, required 000", bus.ram_din); end
    checks++; if (bus.col_addr !== '0 || bus.row_addr !== '0) begin errors++; $display("FAIL rst_addr: got col=%0d row=%0d, required 0 0", bus.col_addr, bus.row_addr); end
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_status: got frame_done=%b busy=%b, required 0 0", frame_done, busy); end
    checks++; if (wr_bank !== 1'b0 || rd_bank !== RD_RST) begin errors++; $display("FAIL rst_banks: got wr=%b rd=%b, required wr=0 rd=%b", wr_bank, rd_bank, RD_RST); end
  endtask

  task automatic test_single_block();
    int n;
    run = 1'b1;
    answer_block(2'd0, 1'd0, 12'hF0A, 1'b0);
    wait_req(10, n);
    checks++;
    if (bus.trace_req !== 1'b1 || bus.col_addr !== 2'd1 || bus.row_addr !== 1'd0) begin
      errors++;
      $display("FAIL single_next_req: got req=%b col=%0d row=%0d, required req=1 col=1 row=0", bus.trace_req, bus.col_addr, bus.row_addr);
    end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL single_we_cnt: got %0d, required 1", we_cnt); end
  endtask

  // also carries the stray events: vs pulse mid-frame, px_valid during ISSUE
  task automatic test_row_wrap();
    vs = 1'b0;
    answer_block(2'd1, 1'd0, 12'h123, 1'b0);
    vs = 1'b1;
    answer_block(2'd2, 1'd0, 12'h456, 1'b1);
    answer_block(2'd3, 1'd0, 12'h789, 1'b0);
    answer_block(2'd0, 1'd1, 12'hABC, 1'b0);
    @(negedge clk);
    checks++; if (we_cnt !== 5 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_writes: got %0d writes, %0d pending, required 5, 0", we_cnt, exp_q.size()); end
    checks++; if (wr_bank !== 1'b0 || rd_bank !== RD_RST) begin errors++; $display("FAIL stray_banks: got wr=%b rd=%b, required wr=0 rd=%b", wr_bank, rd_bank, RD_RST); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b, required 1", busy); end
  endtask

  task automatic test_frame_end();
    int n;
    bit bad;
    answer_block(2'd1, 1'd1, 12'h111, 1'b0);
    answer_block(2'd2, 1'd1, 12'h222, 1'b0);
    answer_block(2'd3, 1'd1, 12'h333, 1'b0);
    @(negedge clk);
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_cnt: got %0d, required 1", fd_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b, required 1", busy); end
`ifdef TRACE_DOUBLE_BUFFER_EN
    bad = 1'b0;
    repeat (15) begin
      if (bus.trace_req !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++; $display("FAIL hold_wait: got early req or busy drop, required hold until vs"); end
    vs = 1'b0;
    @(negedge clk);
    n = 1;
    while (bus.trace_req !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.trace_req !== 1'b1 || n > 4) begin errors++; $display("FAIL vs_restart: got req=%b after %0d cycles, required req=1 within 4", bus.trace_req, n); end
    checks++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin errors++; $display("FAIL bank_swap: got wr=%b rd=%b, required wr=1 rd=0", wr_bank, rd_bank); end
    vs = 1'b1;
`else
    wait_req(4, n);
    checks++; if (bus.trace_req !== 1'b1) begin errors++; $display("FAIL hold_restart: got req=%b, required 1 within 4 cycles", bus.trace_req); end
    checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin errors++; $display("FAIL fixed_banks: got wr=%b rd=%b, required 0 0", wr_bank, rd_bank); end
`endif
    checks++; if (bus.col_addr !== '0 || bus.row_addr !== '0) begin errors++; $display("FAIL frame2_addr: got col=%0d row=%0d, required 0 0", bus.col_addr, bus.row_addr); end
    checks++; if (we_cnt !== 8 || fd_cnt !== 1) begin errors++; $display("FAIL frame_totals: got we=%0d fd=%0d, required 8 1", we_cnt, fd_cnt); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);  // now in WAIT for block (0,0)
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.px_valid = 1'b1;
    bus.px_data  = 12'hDEF;
    @(negedge clk);
    bus.px_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (we_cnt !== 8) begin errors++; $display("FAIL rst_wait_we: got %0d writes, required 8", we_cnt); end
    checks++; if (busy !== 1'b0 || bus.trace_req !== 1'b0) begin errors++; $display("FAIL rst_wait_idle: got busy=%b req=%b, required 0 0", busy, bus.trace_req); end
    checks++; if (bus.col_addr !== '0 || bus.row_addr !== '0) begin errors++; $display("FAIL rst_wait_addr: got col=%0d row=%0d, required 0 0", bus.col_addr, bus.row_addr); end
    checks++; if (wr_bank !== 1'b0 || rd_bank !== RD_RST) begin errors++; $display("FAIL rst_wait_banks: got wr=%b rd=%b, required wr=0 rd=%b", wr_bank, rd_bank, RD_RST); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_row_wrap();
    test_frame_end();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
